// File: rtl/otter_arb_pkg.sv
// Shared types for the data-memory port-2 arbiter.
//   arb_id_t   : identifies a requester (or nobody) for grant, ownership and
//                read-return routing.
//   MEM_SIZE_* : MEM_SIZE encodings carried through unchanged to the memory.
//   mem_req_t  : one access as presented to the memory (store flag, address,
//                store data, size, sign mode).
package otter_arb_pkg;

    typedef enum logic [1:0] {
        ARB_NONE = 2'd0,
        ARB_M0   = 2'd1,
        ARB_M1   = 2'd2
    } arb_id_t;

    localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
    localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
    localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;

    typedef struct packed {
        logic                  we;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
        logic [1:0]            size;
        logic                  sign;
    } mem_req_t;

endpackage

// File: rtl/dmem_arb_prio.sv
// Winner selection for the two memory requesters plus the M1 starvation
// counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   m0_req     : M0 requesting this cycle
//   m1_req     : M1 requesting this cycle
//   m1_lock    : M1 asks to keep ownership across back-to-back accesses
//   owner      : requester granted in the previous cycle (ARB_NONE if idle)
//   winner     : requester granted this cycle (combinational)
module dmem_arb_prio
    import otter_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    m0_req,
    input  logic    m1_req,
    input  logic    m1_lock,
    input  arb_id_t owner,
    output arb_id_t winner
);

    localparam int               CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_d;
    logic [CNT_W-1:0] starve_q;

    // Lock only extends an ownership M1 already holds; it can never take the
    // port away from M0 or claim it from idle.
    always_comb begin
        winner = ARB_NONE;
        if (owner == ARB_M1 && m1_lock && m1_req) begin
            winner = ARB_M1;
        end else if (starve_q == CNT_MAX && m1_req) begin
            winner = ARB_M1;
        end else if (m0_req) begin
            winner = ARB_M0;
        end else if (m1_req) begin
            winner = ARB_M1;
        end
    end

    // Counts consecutive denied M1 cycles, saturating; any M1 grant or a
    // withdrawn M1 request starts the count over.
    always_comb begin
        starve_d = '0;
        if (m1_req && winner != ARB_M1) begin
            starve_d = (starve_q == CNT_MAX) ? starve_q : starve_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares memory data port 2 between M0 (core load/store path) and M1
// (DMA / program loader). One access per cycle, granted combinationally;
// load data returns one cycle after its grant and is routed to the issuer.
//   clk, rst_n          : clock, asynchronous active-low reset
//   m0_* / m1_*         : req, we, addr, wdata, size, sign in; gnt, rvalid,
//                         rdata out; m1_lock holds M1 ownership for bursts
//   mem_rden2, mem_we2  : read / write strobes to the memory
//   mem_addr2, mem_din2,
//   mem_size, mem_sign  : access fields to the memory (held when idle)
//   mem_dout2           : memory read data, valid one cycle after mem_rden2
module dmem_port_arbiter
    import otter_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [1:0]        m0_size,
    input  logic              m0_sign,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [1:0]        m1_size,
    input  logic              m1_sign,
    input  logic              m1_lock,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_rden2,
    output logic              mem_we2,
    output logic [ADDR_W-1:0] mem_addr2,
    output logic [DATA_W-1:0] mem_din2,
    output logic [1:0]        mem_size,
    output logic              mem_sign,
    input  logic [DATA_W-1:0] mem_dout2
);

    arb_id_t  winner;
    arb_id_t  owner_d, owner_q;
    arb_id_t  rd_id_d, rd_id_q;
    logic     rd_pend_d, rd_pend_q;
    mem_req_t held_d, held_q;
    mem_req_t sel;
    logic     m0_req_g, m1_req_g;

    // Requests are masked while reset is asserted so no grant (and hence no
    // memory strobe) can escape during reset.
    assign m0_req_g = m0_req & rst_n;
    assign m1_req_g = m1_req & rst_n;

    dmem_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .clk     (clk),
        .rst_n   (rst_n),
        .m0_req  (m0_req_g),
        .m1_req  (m1_req_g),
        .m1_lock (m1_lock),
        .owner   (owner_q),
        .winner  (winner)
    );

    // Idle cycles replay the last granted fields so the memory-side address
    // and data buses never toggle without an access.
    always_comb begin
        sel = held_q;
        case (winner)
            ARB_M0: begin
                sel.we    = m0_we;
                sel.addr  = ARB_ADDR_W'(m0_addr);
                sel.wdata = ARB_DATA_W'(m0_wdata);
                sel.size  = m0_size;
                sel.sign  = m0_sign;
            end
            ARB_M1: begin
                sel.we    = m1_we;
                sel.addr  = ARB_ADDR_W'(m1_addr);
                sel.wdata = ARB_DATA_W'(m1_wdata);
                sel.size  = m1_size;
                sel.sign  = m1_sign;
            end
            default: ;
        endcase
    end

    always_comb begin
        m0_gnt    = (winner == ARB_M0);
        m1_gnt    = (winner == ARB_M1);
        mem_rden2 = (winner != ARB_NONE) && !sel.we;
        mem_we2   = (winner != ARB_NONE) && sel.we;
        mem_addr2 = sel.addr[ADDR_W-1:0];
        mem_din2  = sel.wdata[DATA_W-1:0];
        mem_size  = sel.size;
        mem_sign  = sel.sign;

        held_d    = sel;
        owner_d   = winner;
        rd_pend_d = mem_rden2;
        rd_id_d   = winner;
    end

    // Read data passes straight through from the memory to whichever
    // requester issued the load one cycle earlier; the other sees zero.
    always_comb begin
        m0_rvalid = rd_pend_q && (rd_id_q == ARB_M0);
        m1_rvalid = rd_pend_q && (rd_id_q == ARB_M1);
        m0_rdata  = m0_rvalid ? mem_dout2 : '0;
        m1_rdata  = m1_rvalid ? mem_dout2 : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q   <= ARB_NONE;
            rd_id_q   <= ARB_NONE;
            rd_pend_q <= 1'b0;
            held_q    <= '0;
        end else begin
            owner_q   <= owner_d;
            rd_id_q   <= rd_id_d;
            rd_pend_q <= rd_pend_d;
            held_q    <= held_d;
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Testbench for dmem_port_arbiter: behavioural synchronous memory on port 2,
// a scoreboard of expected load returns, and one task per scenario.
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m0_sign;
    logic [31:0] m0_addr, m0_wdata;
    logic [1:0]  m0_size;
    logic        m0_gnt, m0_rvalid;
    logic [31:0] m0_rdata;
    logic        m1_req, m1_we, m1_sign, m1_lock;
    logic [31:0] m1_addr, m1_wdata;
    logic [1:0]  m1_size;
    logic        m1_gnt, m1_rvalid;
    logic [31:0] m1_rdata;
    logic        mem_rden2, mem_we2, mem_sign;
    logic [31:0] mem_addr2, mem_din2, mem_dout2;
    logic [1:0]  mem_size;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int rv_cnt0 = 0;
    int rv_cnt1 = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .STARVE_MAX (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_size   (m0_size),
        .m0_sign   (m0_sign),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_size   (m1_size),
        .m1_sign   (m1_sign),
        .m1_lock   (m1_lock),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .mem_rden2 (mem_rden2),
        .mem_we2   (mem_we2),
        .mem_addr2 (mem_addr2),
        .mem_din2  (mem_din2),
        .mem_size  (mem_size),
        .mem_sign  (mem_sign),
        .mem_dout2 (mem_dout2)
    );

    // ---------------- memory model ----------------
    logic [31:0]   mem [0:1023];
    logic [1023:0] wr_valid;
    logic          model_clr;

    // Unwritten words read back a fixed pattern; 0x100 holds 0xDEADBEEF.
    function automatic logic [31:0] model_rd(input logic [31:0] a);
        if (wr_valid[a[11:2]]) return mem[a[11:2]];
        if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
        return {16'hA5A5, a[15:0]};
    endfunction

    always @(posedge clk) begin
        if (model_clr) begin
            wr_valid  <= '0;
            mem_dout2 <= '0;
        end else begin
            if (mem_we2) begin
                mem[mem_addr2[11:2]]      <= mem_din2;
                wr_valid[mem_addr2[11:2]] <= 1'b1;
            end
            if (mem_rden2) mem_dout2 <= model_rd(mem_addr2);
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic        id;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t sb[$];

    always @(negedge clk) begin
        exp_t        e;
        logic        v0, v1;
        logic [31:0] d0, d1;
        v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            if (e.id) begin v1 = 1'b1; d1 = e.data; end
            else      begin v0 = 1'b0 | 1'b1; d0 = e.data; end
        end
        checks++;
        if (m0_rvalid !== v0 || m0_rdata !== d0) begin
            errors++;
            $display("FAIL sb_m0_ret cyc=%0d got rvalid=%b rdata=%h want rvalid=%b rdata=%h",
                     cyc, m0_rvalid, m0_rdata, v0, d0);
        end
        checks++;
        if (m1_rvalid !== v1 || m1_rdata !== d1) begin
            errors++;
            $display("FAIL sb_m1_ret cyc=%0d got rvalid=%b rdata=%h want rvalid=%b rdata=%h",
                     cyc, m1_rvalid, m1_rdata, v1, d1);
        end
        if (m0_rvalid === 1'b1) rv_cnt0++;
        if (m1_rvalid === 1'b1) rv_cnt1++;
        if (m0_gnt === 1'b1 && !m0_we) sb.push_back('{1'b0, model_rd(m0_addr), cyc + 1});
        if (m1_gnt === 1'b1 && !m1_we) sb.push_back('{1'b1, model_rd(m1_addr), cyc + 1});
        if (m0_gnt === 1'b1 || m1_gnt === 1'b1)
            $display("cyc=%0d gnt m0=%b m1=%b we=%b addr=%h din=%h",
                     cyc, m0_gnt, m1_gnt, mem_we2, mem_addr2, mem_din2);
        cyc++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv0(input logic req, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata);
        m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
        m0_size = 2'b10; m0_sign = 1'b0;
    endtask

    task automatic drv1(input logic req, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic lock);
        m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        m1_size = 2'b10; m1_sign = 1'b0; m1_lock = lock;
    endtask

    task automatic idle();
        drv0(1'b0, 1'b0, 32'h0, 32'h0);
        drv1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [71:0] outs;
        drv0(1'b1, 1'b0, 32'h100, 32'h0);
        drv1(1'b1, 1'b1, 32'h104, 32'h5, 1'b1);
        @(negedge clk);
        outs = {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_rden2, mem_we2,
                mem_size, mem_sign, mem_addr2[30:0], m0_rdata[15:0], m1_rdata[15:0]};
        checks++;
        if (outs !== '0 || mem_din2 !== '0 || mem_addr2 !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h din=%h addr=%h want all zero", outs, mem_din2, mem_addr2);
        end
        idle();
        step();
        rst_n = 1'b1;
        model_clr = 1'b0;
        step();
    endtask

    task automatic test_m0_load();
        drv0(1'b1, 1'b0, 32'h100, 32'h0);
        @(negedge clk);
        checks++;
        if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
            errors++;
            $display("FAIL m0_load_gnt got m0=%b m1=%b want m0=1 m1=0", m0_gnt, m1_gnt);
        end
        checks++;
        if (mem_rden2 !== 1'b1 || mem_we2 !== 1'b0 || mem_addr2 !== 32'h100 || mem_size !== 2'b10) begin
            errors++;
            $display("FAIL m0_load_bus got rden=%b we=%b addr=%h size=%b want 1 0 00000100 10",
                     mem_rden2, mem_we2, mem_addr2, mem_size);
        end
        step();
        idle();
        @(negedge clk);
        checks++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL m0_load_data got rvalid=%b rdata=%h want 1 deadbeef", m0_rvalid, m0_rdata);
        end
        checks++;
        if (mem_rden2 !== 1'b0 || mem_addr2 !== 32'h100 || mem_size !== 2'b10) begin
            errors++;
            $display("FAIL idle_hold got rden=%b addr=%h size=%b want 0 00000100 10",
                     mem_rden2, mem_addr2, mem_size);
        end
        step();
    endtask

    task automatic test_starvation();
        logic exp1;
        idle();
        step();
        for (int i = 0; i < 10; i++) begin
            drv0(1'b1, 1'b0, 32'h300, 32'h0);
            drv1(1'b1, 1'b0, 32'h380, 32'h0, 1'b0);
            @(negedge clk);
            exp1 = ((i % 5) == 4);
            checks++;
            if (m1_gnt !== exp1 || m0_gnt !== !exp1) begin
                errors++;
                $display("FAIL starve_c%0d got m0=%b m1=%b want m0=%b m1=%b",
                         i, m0_gnt, m1_gnt, !exp1, exp1);
            end
            step();
        end
        idle();
        step();
    endtask

    task automatic test_lock();
        logic [31:0] wd [3];
        wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33;
        idle();
        step();
        for (int i = 0; i < 3; i++) begin
            drv0(i != 0, 1'b0, 32'h300, 32'h0);
            drv1(1'b1, 1'b1, 32'h500 + 32'(4 * i), wd[i], 1'b1);
            @(negedge clk);
            checks++;
            if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0 || mem_we2 !== 1'b1 || mem_din2 !== wd[i]) begin
                errors++;
                $display("FAIL lock_store%0d got m0=%b m1=%b we=%b din=%h want 0 1 1 %h",
                         i, m0_gnt, m1_gnt, mem_we2, mem_din2, wd[i]);
            end
            step();
        end
        drv1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        checks++;
        if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
            errors++;
            $display("FAIL lock_release got m0=%b m1=%b want m0=1 m1=0", m0_gnt, m1_gnt);
        end
        step();
        idle();
        step();
        // lock asserted with no prior M1 ownership must not beat M0
        drv0(1'b1, 1'b0, 32'h300, 32'h0);
        drv1(1'b1, 1'b1, 32'h50C, 32'h44, 1'b1);
        @(negedge clk);
        checks++;
        if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
            errors++;
            $display("FAIL lock_no_preempt got m0=%b m1=%b want m0=1 m1=0", m0_gnt, m1_gnt);
        end
        step();
        drv0(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        checks++;
        if (m1_gnt !== 1'b1 || mem_addr2 !== 32'h50C) begin
            errors++;
            $display("FAIL lock_m1_after got m1=%b addr=%h want 1 0000050c", m1_gnt, mem_addr2);
        end
        step();
        drv1(1'b1, 1'b0, 32'h504, 32'h0, 1'b0);
        step();
        idle();
        @(negedge clk);
        checks++;
        if (m1_rvalid !== 1'b1 || m1_rdata !== 32'h22) begin
            errors++;
            $display("FAIL lock_readback got rvalid=%b rdata=%h want 1 00000022", m1_rvalid, m1_rdata);
        end
        step();
    endtask

    task automatic test_alternating();
        int c0, c1;
        c0 = rv_cnt0;
        c1 = rv_cnt1;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) begin
                drv0(1'b1, 1'b0, 32'h600 + 32'(4 * i), 32'h0);
                drv1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
            end else begin
                drv0(1'b0, 1'b0, 32'h0, 32'h0);
                drv1(1'b1, 1'b0, 32'h600 + 32'(4 * i), 32'h0, 1'b0);
            end
            @(negedge clk);
            checks++;
            if (m0_gnt !== (i % 2 == 0) || m1_gnt !== (i % 2 == 1)) begin
                errors++;
                $display("FAIL alt_gnt%0d got m0=%b m1=%b", i, m0_gnt, m1_gnt);
            end
            step();
        end
        idle();
        step();
        step();
        checks++;
        if (rv_cnt0 - c0 != 4 || rv_cnt1 - c1 != 4) begin
            errors++;
            $display("FAIL alt_returns got m0=%0d m1=%0d want 4 4", rv_cnt0 - c0, rv_cnt1 - c1);
        end
    endtask

    task automatic test_store_load();
        drv1(1'b1, 1'b1, 32'h200, 32'h55, 1'b0);
        @(negedge clk);
        checks++;
        if (m1_gnt !== 1'b1 || mem_we2 !== 1'b1 || mem_rden2 !== 1'b0 ||
            mem_addr2 !== 32'h200 || mem_din2 !== 32'h55) begin
            errors++;
            $display("FAIL st_issue got gnt=%b we=%b rden=%b addr=%h din=%h",
                     m1_gnt, mem_we2, mem_rden2, mem_addr2, mem_din2);
        end
        step();
        drv1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        drv0(1'b1, 1'b0, 32'h200, 32'h0);
        step();
        idle();
        @(negedge clk);
        checks++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h0000_0055) begin
            errors++;
            $display("FAIL ld_after_st got rvalid=%b rdata=%h want 1 00000055", m0_rvalid, m0_rdata);
        end
        step();
    endtask

    task automatic test_reset_midread();
        drv0(1'b1, 1'b0, 32'h100, 32'h0);
        @(negedge clk);
        checks++;
        if (m0_gnt !== 1'b1) begin
            errors++;
            $display("FAIL rmr_gnt got %b want 1", m0_gnt);
        end
        step();
        rst_n = 1'b0;
        sb.delete();
        drv1(1'b1, 1'b0, 32'h380, 32'h0, 1'b1);
        @(negedge clk);
        checks++;
        if (m0_rvalid !== 1'b0 || m0_rdata !== '0 || m0_gnt !== 1'b0 || m1_gnt !== 1'b0 ||
            mem_rden2 !== 1'b0 || mem_addr2 !== '0 || mem_size !== 2'b00) begin
            errors++;
            $display("FAIL rmr_dropped got rvalid=%b rdata=%h gnt=%b%b rden=%b addr=%h size=%b want all 0",
                     m0_rvalid, m0_rdata, m0_gnt, m1_gnt, mem_rden2, mem_addr2, mem_size);
        end
        step();
        rst_n = 1'b1;
        drv0(1'b1, 1'b0, 32'h300, 32'h0);
        @(negedge clk);
        checks++;
        if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
            errors++;
            $display("FAIL rmr_prio got m0=%b m1=%b want m0=1 m1=0", m0_gnt, m1_gnt);
        end
        step();
        idle();
        step();
        step();
    endtask

    initial begin
        rst_n     = 1'b0;
        model_clr = 1'b1;
        idle();
        step();
        test_reset();
        test_m0_load();
        test_starvation();
        test_lock();
        test_alternating();
        test_store_load();
        test_reset_midread();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
